// File: rtl/task_mem_bank_ctrl.sv
// ============================================================================
// Module      : task_mem_bank_ctrl
// Description : Double-buffered task memory; host fills one bank while the
//               scheduler reads the other, banks swap on scheduler release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module task_mem_bank_ctrl #(
    parameter int TM_WIDTH = 32,
    parameter int TM_DEPTH = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [TM_WIDTH-1:0] wr_data,
    input  logic                wr_last,
    input  logic [ADDR_W-1:0]   rd_ptr,
    output logic [TM_WIDTH-1:0] rd_data,
    input  logic                rd_done,
    output logic                bank_valid,
    output logic [ADDR_W:0]     rd_len,
    output logic                active_bank,
    output logic                fill_bank,
    output logic                err_trunc
);

    localparam logic [0:0] W_FILL   = 1'b0;
    localparam logic [0:0] W_STALL  = 1'b1;
    localparam logic [0:0] R_EMPTY  = 1'b0;
    localparam logic [0:0] R_ACTIVE = 1'b1;

    logic [TM_WIDTH-1:0] r_mem [2][TM_DEPTH];
    logic [1:0]          r_full;
    logic [ADDR_W:0]     r_len [2];
    logic [ADDR_W-1:0]   r_wptr;
    logic                r_fill_bank;
    logic                r_active_bank;
    logic                r_err_trunc;
    logic [0:0]          r_rd_state;

    logic [0:0]          w_wr_state;
    logic                w_accept;
    logic                w_wrap;
    logic                w_close;
    logic                w_other;
    logic                w_handover;
    logic [ADDR_W:0]     w_act_len;

    // The writer stalls exactly while the bank it would fill still holds a program.
    assign w_wr_state = r_full[r_fill_bank] ? W_STALL : W_FILL;
    assign wr_ready   = (w_wr_state == W_FILL);
    assign w_accept   = wr_valid & wr_ready;
    assign w_wrap     = (r_wptr == ADDR_W'(TM_DEPTH - 1));
    assign w_close    = w_accept & (wr_last | w_wrap);
    assign w_other    = ~r_active_bank;
    assign w_handover = r_full[w_other] | (w_close & (r_fill_bank == w_other));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full        <= '0;
            r_len[0]      <= '0;
            r_len[1]      <= '0;
            r_wptr        <= '0;
            r_fill_bank   <= 1'b0;
            r_active_bank <= 1'b0;
            r_err_trunc   <= 1'b0;
            r_rd_state    <= R_EMPTY;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_full[r_fill_bank] <= 1'b1;
                    r_len[r_fill_bank]  <= {1'b0, r_wptr} + (ADDR_W + 1)'(1);
                    r_wptr              <= '0;
                    r_fill_bank         <= ~r_fill_bank;
                    if (w_wrap && !wr_last) begin
                        r_err_trunc <= 1'b1;
                    end
                end else begin
                    r_wptr <= r_wptr + ADDR_W'(1);
                end
            end
            case (r_rd_state)
                R_EMPTY: begin
                    if (r_full[r_active_bank]) begin
                        r_rd_state <= R_ACTIVE;
                    end
                end
                default: begin
                    // Release frees a bank the writer never closes into this cycle.
                    if (rd_done) begin
                        r_full[r_active_bank] <= 1'b0;
                        r_active_bank         <= ~r_active_bank;
                        r_rd_state            <= w_handover ? R_ACTIVE : R_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            r_mem[r_fill_bank][r_wptr] <= wr_data;
        end
    end

    assign bank_valid  = (r_rd_state == R_ACTIVE);
    assign w_act_len   = r_len[r_active_bank];
    assign rd_len      = bank_valid ? w_act_len : '0;
    assign rd_data     = (bank_valid && ({1'b0, rd_ptr} < w_act_len))
                         ? r_mem[r_active_bank][rd_ptr] : '0;
    assign active_bank = r_active_bank;
    assign fill_bank   = r_fill_bank;
    assign err_trunc   = r_err_trunc;

endmodule

`default_nettype wire

// File: tb/tb_task_mem_bank_ctrl.sv
// ============================================================================
// Module      : tb_task_mem_bank_ctrl
// Description : Vector table, directed corner sequences and randomized traffic
//               checked against a program-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_task_mem_bank_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [3:0]  rd_ptr = '0;
    logic [31:0] rd_data;
    logic        rd_done = 1'b0;
    logic        bank_valid;
    logic [4:0]  rd_len;
    logic        active_bank;
    logic        fill_bank;
    logic        err_trunc;

    int n_cmp = 0;
    int n_bad = 0;

    task_mem_bank_ctrl #(.TM_WIDTH(32), .TM_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .rd_ptr(rd_ptr), .rd_data(rd_data), .rd_done(rd_done),
        .bank_valid(bank_valid), .rd_len(rd_len),
        .active_bank(active_bank), .fill_bank(fill_bank), .err_trunc(err_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic        wv;
        logic [31:0] wd;
        logic        wl;
        logic [3:0]  rp;
        logic        rd;
        logic        e_ready;
        logic        e_valid;
        logic [4:0]  e_len;
        logic [31:0] e_data;
        logic        e_act;
        logic        e_fill;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    // Reference model: FIFO of completed programs (front = program being read).
    logic [31:0] pd [2][16];
    int          pl [2];
    int          m_cnt;
    logic [31:0] part [16];
    int          plen;
    logic        m_valid, m_act, m_fill, m_err;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic wv, input logic [31:0] wd,
                       input logic wl, input logic [3:0] rp, input logic rd);
        @(negedge clk);
        reset    = r;
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        rd_ptr   = rp;
        rd_done  = rd;
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; plen = 0;
        m_valid = 1'b0; m_act = 1'b0; m_fill = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic wv, input logic [31:0] wd,
                              input logic wl, input logic rd);
        logic acc, was_v;
        int   cb;
        if (!r) begin
            model_reset();
        end else begin
            acc   = wv && (m_cnt < 2);
            was_v = m_valid;
            cb    = m_cnt;
            if (acc) begin
                part[plen] = wd;
                if (wl || plen == 15) begin
                    if (!wl) m_err = 1'b1;
                    pd[m_cnt] = part;
                    pl[m_cnt] = plen + 1;
                    m_cnt++;
                    plen = 0;
                    m_fill = ~m_fill;
                end else begin
                    plen++;
                end
            end
            if (!was_v) begin
                if (cb > 0) m_valid = 1'b1;
            end else if (rd) begin
                pd[0] = pd[1];
                pl[0] = pl[1];
                m_cnt--;
                m_act = ~m_act;
                m_valid = (m_cnt > 0);
            end
        end
    endtask

    initial begin
        //            chk rst wv wd     wl rp rd  rdy val len data   act fil err
        vq.push_back('{0, 0, 0, 32'h0,  0, 0, 0,  0,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{0, 0, 0, 32'h0,  0, 0, 0,  0,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 0, 0,  1,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{1, 1, 1, 32'hA1, 0, 0, 0,  1,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{1, 1, 1, 32'hA2, 0, 0, 0,  1,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{1, 1, 1, 32'hA3, 1, 0, 0,  1,  0,  0, 32'h0,  0,  0,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 1, 0,  1,  0,  0, 32'h0,  0,  1,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 1, 0,  1,  1,  3, 32'hA2, 0,  1,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 5, 0,  1,  1,  3, 32'h0,  0,  1,  0});
        vq.push_back('{1, 1, 1, 32'hB1, 0, 0, 0,  1,  1,  3, 32'hA1, 0,  1,  0});
        vq.push_back('{1, 1, 1, 32'hB2, 1, 0, 0,  1,  1,  3, 32'hA1, 0,  1,  0});
        vq.push_back('{1, 1, 1, 32'hEE, 0, 0, 0,  0,  1,  3, 32'hA1, 0,  0,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 0, 1,  0,  1,  3, 32'hA1, 0,  0,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 0, 0,  1,  1,  2, 32'hB1, 1,  0,  0});
        vq.push_back('{1, 1, 1, 32'hD1, 0, 1, 0,  1,  1,  2, 32'hB2, 1,  0,  0});
        vq.push_back('{1, 1, 1, 32'hD2, 1, 1, 1,  1,  1,  2, 32'hB2, 1,  0,  0});
        vq.push_back('{1, 1, 0, 32'h0,  0, 0, 0,  1,  1,  2, 32'hD1, 0,  1,  0});

        foreach (vq[i]) begin
            cyc(vq[i].rst_n, vq[i].wv, vq[i].wd, vq[i].wl, vq[i].rp, vq[i].rd);
            if (vq[i].chk) begin
                chk($sformatf("vec%0d.wr_ready", i),    wr_ready,    vq[i].e_ready);
                chk($sformatf("vec%0d.bank_valid", i),  bank_valid,  vq[i].e_valid);
                chk($sformatf("vec%0d.rd_len", i),      rd_len,      vq[i].e_len);
                chk($sformatf("vec%0d.rd_data", i),     rd_data,     vq[i].e_data);
                chk($sformatf("vec%0d.active_bank", i), active_bank, vq[i].e_act);
                chk($sformatf("vec%0d.fill_bank", i),   fill_bank,   vq[i].e_fill);
                chk($sformatf("vec%0d.err_trunc", i),   err_trunc,   vq[i].e_err);
            end
        end

        // Truncation: 16 beats without wr_last into bank 1 while bank 0 is read.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 32'(i), 0, 0, 0);
            chk("trunc.ready_during_fill", wr_ready, 1);
            chk("trunc.err_before_close", err_trunc, 0);
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("trunc.err_set", err_trunc, 1);
        chk("trunc.stalled", wr_ready, 0);
        chk("trunc.fill_bank", fill_bank, 0);
        chk("trunc.old_len", rd_len, 2);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 15, 0);
        chk("trunc.active_bank", active_bank, 1);
        chk("trunc.rd_len", rd_len, 16);
        chk("trunc.last_frame", rd_data, 32'h0F);
        chk("trunc.err_sticky", err_trunc, 1);
        chk("trunc.ready_back", wr_ready, 1);
        cyc(1, 0, 0, 0, 8, 0);
        chk("trunc.mid_frame", rd_data, 32'h08);

        // Reset mid-fill discards the partial program.
        cyc(1, 1, 32'hE1, 0, 0, 0);
        cyc(1, 1, 32'hE2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'hC1, 1, 0, 0);
        chk("rstfill.ready", wr_ready, 1);
        chk("rstfill.valid", bank_valid, 0);
        chk("rstfill.err_cleared", err_trunc, 0);
        chk("rstfill.fill_bank", fill_bank, 0);
        chk("rstfill.rd_data", rd_data, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rstfill.valid_latency", bank_valid, 0);
        chk("rstfill.fill_after", fill_bank, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rstfill.valid", bank_valid, 1);
        chk("rstfill.active_bank", active_bank, 0);
        chk("rstfill.rd_len", rd_len, 1);
        chk("rstfill.rd_data", rd_data, 32'hC1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("rstfill.beyond_len", rd_data, 0);

        // Randomized traffic against the program-queue model.
        cyc(0, 0, 0, 0, 0, 0);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic        r, wv, wl, rd;
            logic [31:0] wd;
            logic [3:0]  rp;
            logic [31:0] e_data;
            r  = ($urandom_range(0, 79) != 0);
            wv = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            wl = ($urandom_range(0, 5) == 0);
            rp = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 4) == 0);
            cyc(r, wv, wd, wl, rp, rd);
            e_data = (m_valid && int'(rp) < pl[0]) ? pd[0][rp] : 32'h0;
            chk("rnd.wr_ready", wr_ready, (m_cnt < 2));
            chk("rnd.bank_valid", bank_valid, m_valid);
            chk("rnd.rd_len", rd_len, m_valid ? 5'(pl[0]) : 5'd0);
            chk("rnd.rd_data", rd_data, e_data);
            chk("rnd.active_bank", active_bank, m_act);
            chk("rnd.fill_bank", fill_bank, m_fill);
            chk("rnd.err_trunc", err_trunc, m_err);
            model_step(r, wv, wd, wl, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
